// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter between two byte requesters feeding
// one UART transmit line (start, data LSB first, optional parity, stop bits).
module uart_tx_scheduler #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dev0_valid,
  input  logic [DATA_WIDTH-1:0] dev0_data,
  output logic                  dev0_ready,
  input  logic                  dev1_valid,
  input  logic [DATA_WIDTH-1:0] dev1_data,
  output logic                  dev1_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity over the data word; odd parity is the inverted even parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
    return (^data) ^ (PARITY_ODD != 0);
  endfunction

  logic [2:0]            state_q,      state_d;
  logic [BAUD_W-1:0]     baud_q,       baud_d;
  logic [BIT_W-1:0]      bit_q,        bit_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic                  parity_q,     parity_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_id_q,   grant_id_d;
  logic                  tx_q,         tx_d;
  logic                  busy_q,       busy_d;
  logic                  frame_done_q, frame_done_d;

  logic grant_sel;
  logic baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // Round-robin grant and combinational ready, offered only while idle.
  always_comb begin
    grant_sel  = 1'b0;
    dev0_ready = 1'b0;
    dev1_ready = 1'b0;
    if (dev0_valid && dev1_valid) begin
      grant_sel = ~last_grant_q;
    end else if (dev1_valid) begin
      grant_sel = 1'b1;
    end else begin
      grant_sel = 1'b0;
    end
    if (!rst && (state_q == S_IDLE)) begin
      dev0_ready = dev0_valid && !grant_sel;
      dev1_ready = dev1_valid && grant_sel;
    end else begin
      dev0_ready = 1'b0;
      dev1_ready = 1'b0;
    end
  end

  // Frame sequencer: state, baud/bit counters, shift register and grant history.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    case (state_q)
      S_IDLE: begin
        baud_d = BAUD_ZERO;
        bit_d  = BIT_ZERO;
        if (dev0_ready || dev1_ready) begin
          state_d      = S_START;
          shift_d      = grant_sel ? dev1_data : dev0_data;
          parity_d     = calc_parity(grant_sel ? dev1_data : dev0_data);
          last_grant_d = grant_sel;
          grant_id_d   = grant_sel;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = BAUD_ZERO;
          bit_d   = BIT_ZERO;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = BAUD_ZERO;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_d   = BIT_ZERO;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          baud_d  = BAUD_ZERO;
          bit_d   = BIT_ZERO;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = BAUD_ZERO;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = BIT_ZERO;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = BAUD_ZERO;
        bit_d   = BIT_ZERO;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_q       <= BAUD_ZERO;
      bit_q        <= BIT_ZERO;
      shift_q      <= {DATA_WIDTH{1'b0}};
      parity_q     <= 1'b0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: two instances (even parity / 1 stop bit and
// odd parity / 2 stop bits) checked every cycle against a frame-level model.
module tb_uart_tx_scheduler;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] v0, v1;
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic [1:0] tx_o, busy_o, gid_o, fd_o, r0_o, r1_o;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.CLK_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(1),
                      .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst),
    .dev0_valid(v0[0]), .dev0_data(d0[0]), .dev0_ready(r0_o[0]),
    .dev1_valid(v1[0]), .dev1_data(d1[0]), .dev1_ready(r1_o[0]),
    .tx(tx_o[0]), .busy(busy_o[0]), .grant_id(gid_o[0]), .frame_done(fd_o[0])
  );

  uart_tx_scheduler #(.CLK_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(1),
                      .PARITY_ODD(1), .STOP_BITS(2)) u_odd (
    .clk(clk), .rst(rst),
    .dev0_valid(v0[1]), .dev0_data(d0[1]), .dev0_ready(r0_o[1]),
    .dev1_valid(v1[1]), .dev1_data(d1[1]), .dev1_ready(r1_o[1]),
    .tx(tx_o[1]), .busy(busy_o[1]), .grant_id(gid_o[1]), .frame_done(fd_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of serial bits, each CPB cycles long.
  bit m_busy   [2];
  int m_cnt    [2];
  int m_len    [2];
  bit m_bits   [2][32];
  bit m_last   [2];
  bit m_gid    [2];
  bit m_acc    [2];
  bit m_accdev [2];

  function automatic int stop_bits(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic build_frame(input int i, input logic [7:0] data);
    logic par;
    par = 1'b0;
    m_bits[i][0] = 1'b0;
    for (int b = 0; b < DW; b++) begin
      m_bits[i][1 + b] = data[b];
      par = par ^ data[b];
    end
    m_bits[i][1 + DW] = (i == 1) ? ~par : par;
    for (int s = 0; s < stop_bits(i); s++) m_bits[i][2 + DW + s] = 1'b1;
    m_len[i] = CPB * (1 + DW + 1 + stop_bits(i));
  endtask

  // Compare every output, then advance the model across the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit g, e0, e1, etx, efd;
      string sfx;
      sfx = (i == 0) ? "_even" : "_odd";
      g = 1'b0;
      if (v0[i] && v1[i]) g = ~m_last[i];
      else if (v1[i]) g = 1'b1;
      e0 = !rst && !m_busy[i] && v0[i] && !g;
      e1 = !rst && !m_busy[i] && v1[i] && g;
      etx = m_busy[i] ? m_bits[i][m_cnt[i] / CPB] : 1'b1;
      efd = m_busy[i] && (m_cnt[i] == m_len[i] - 1);
      check_eq({"dev0_ready", sfx}, 32'(r0_o[i]), 32'(e0));
      check_eq({"dev1_ready", sfx}, 32'(r1_o[i]), 32'(e1));
      check_eq({"tx", sfx}, 32'(tx_o[i]), 32'(etx));
      check_eq({"busy", sfx}, 32'(busy_o[i]), 32'(m_busy[i]));
      check_eq({"frame_done", sfx}, 32'(fd_o[i]), 32'(efd));
      check_eq({"grant_id", sfx}, 32'(gid_o[i]), 32'(m_gid[i]));
      m_acc[i] = 1'b0;
      if (rst) begin
        m_busy[i] = 1'b0;
        m_last[i] = 1'b1;
        m_gid[i]  = 1'b0;
      end else if (!m_busy[i]) begin
        if (e0 || e1) begin
          build_frame(i, e1 ? d1[i] : d0[i]);
          m_busy[i]   = 1'b1;
          m_cnt[i]    = 0;
          m_last[i]   = e1;
          m_gid[i]    = e1;
          m_acc[i]    = 1'b1;
          m_accdev[i] = e1;
        end
      end else if (m_cnt[i] == m_len[i] - 1) begin
        m_busy[i] = 1'b0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle requester behaviour: hold until accepted (or withdraw with
  // probability pwd%), otherwise raise valid with probability p%.
  task automatic drive(input int p0, input int p1, input int pwd, input bit fix,
                       input logic [7:0] f0, input logic [7:0] f1);
    for (int i = 0; i < 2; i++) begin
      if (v0[i] && !(m_acc[i] && !m_accdev[i])) begin
        if ($urandom_range(99) < pwd) v0[i] = 1'b0;
      end else begin
        v0[i] = ($urandom_range(99) < p0);
        d0[i] = fix ? f0 : 8'($urandom);
      end
      if (v1[i] && !(m_acc[i] && m_accdev[i])) begin
        if ($urandom_range(99) < pwd) v1[i] = 1'b0;
      end else begin
        v1[i] = ($urandom_range(99) < p1);
        d1[i] = fix ? f1 : 8'($urandom);
      end
    end
  endtask

  task automatic run(input int n, input int p0, input int p1, input int pwd, input bit fix,
                     input logic [7:0] f0, input logic [7:0] f1);
    repeat (n) begin
      tick();
      drive(p0, p1, pwd, fix, f0, f1);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Advance until instance 0 reaches frame cycle cnt; an expired bound is a failure.
  task automatic wait_cnt(input string tag, input int cnt);
    int k;
    k = 0;
    while (!(m_busy[0] && m_cnt[0] == cnt) && k < 200) begin
      run(1, 0, 0, 0, 1'b0, 8'h00, 8'h00);
      k++;
    end
    check_eq(tag, 32'(k < 200), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_cnt[i] = 0; m_len[i] = 1; m_last[i] = 1'b1;
      m_gid[i] = 1'b0; m_acc[i] = 1'b0; m_accdev[i] = 1'b0;
      d0[i] = 8'h00; d1[i] = 8'h00;
    end
    v0 = 2'b00;
    v1 = 2'b00;
    do_reset(3);

    // Basic frame: dev0 sends A5.
    drive(100, 0, 0, 1'b1, 8'hA5, 8'h00);
    run(60, 0, 0, 0, 1'b1, 8'h00, 8'h00);

    // Contention from reset: dev0 first, then alternating.
    do_reset(2);
    run(200, 100, 100, 0, 1'b1, 8'h55, 8'h0F);
    run(60, 0, 0, 0, 1'b0, 8'h00, 8'h00);

    // Single streaming requester dev1.
    run(160, 0, 100, 0, 1'b0, 8'h00, 8'h00);
    run(60, 0, 0, 0, 1'b0, 8'h00, 8'h00);

    // Odd-parity instance sees an all-zero byte; both instances send 00.
    drive(100, 0, 0, 1'b1, 8'h00, 8'h00);
    run(60, 0, 0, 0, 1'b1, 8'h00, 8'h00);

    // Reset during data bit 3, with both requesters valid in the reset cycle.
    drive(100, 0, 0, 1'b0, 8'h00, 8'h00);
    wait_cnt("wait_data_bit3", CPB * 4 + 1);
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b1; d0[i] = 8'($urandom);
      v1[i] = 1'b1; d1[i] = 8'($urandom);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(60, 0, 0, 0, 1'b0, 8'h00, 8'h00);

    // Request while busy: dev1 raises 3C mid-frame and must wait for idle.
    drive(100, 0, 0, 1'b0, 8'h00, 8'h00);
    wait_cnt("wait_mid_frame", 10);
    drive(0, 100, 0, 1'b1, 8'h00, 8'h3C);
    run(120, 0, 0, 0, 1'b0, 8'h00, 8'h00);

    // Randomized traffic with withdrawals and occasional resets.
    repeat (3000) begin
      tick();
      rst = ($urandom_range(399) == 0);
      drive(30, 30, 5, 1'b0, 8'h00, 8'h00);
    end
    rst = 1'b0;
    v0 = 2'b00;
    v1 = 2'b00;
    run(60, 0, 0, 0, 1'b0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
